calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 3, the maximum decimal digits accepted per operand.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port key_valid, input, 1, a one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have port key_code, input, 4, where 0-9 are digits, 10 is PLUS, 11 is MINUS, 12 is EQUALS, 13 is CLEAR, and 14-15 are ignored.
REQ-006 The block SHALL have port alu_a, output, 8, the registered operand A driven to the add/sub ALU.
REQ-007 The block SHALL have port alu_b, output, 8, the registered operand B driven to the ALU.
REQ-008 The block SHALL have port alu_add_sub, output, 1, driven to the ALU: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have port alu_sum, input, 8, the ALU result.
REQ-010 The block SHALL have port alu_c8, input, 1, the ALU carry-out.
REQ-011 The block SHALL have ports alu_alb, alu_agb and alu_aeb, input, 1 each, the ALU compare flags (A<B, A>B, A==B).
REQ-012 The block SHALL have port disp_value, output, 8, the unsigned magnitude to display.
REQ-013 The block SHALL have port disp_neg, output, 1, the sign to display.
REQ-014 The block SHALL have port err, output, 1, a sticky error flag.
REQ-015 The block SHALL have port result_valid, output, 1, a one-cycle strobe raised when a new result is on disp_value.
REQ-016 The block SHALL have port state_o, output, 3, the current FSM state for debug.

Function
REQ-017 The FSM SHALL have the states ENTER_A, ENTER_B, EXEC, CAPTURE and SHOW.
REQ-018 In ENTER_A, a digit d SHALL update the operand as acc = acc*10 + d, and disp_value SHALL track acc.
REQ-019 A digit SHALL be discarded and err set when the update would exceed 255 or exceed MAX_DIGITS digits; the state SHALL be unchanged.
REQ-020 In ENTER_A, PLUS or MINUS SHALL latch alu_a = acc and alu_add_sub = (MINUS), clear acc, and move to ENTER_B.
REQ-021 In ENTER_A, EQUALS SHALL be ignored.
REQ-022 In ENTER_B, digits SHALL accumulate as in ENTER_A.
REQ-023 In ENTER_B, EQUALS SHALL latch alu_b = acc and move to EXEC.
REQ-024 In ENTER_B, PLUS or MINUS SHALL overwrite alu_add_sub only.
REQ-025 EXEC SHALL last exactly one cycle, holding alu_a, alu_b and alu_add_sub stable for the combinational ALU.
REQ-026 CAPTURE SHALL last one cycle and register the ALU outputs.
REQ-027 In CAPTURE when adding: disp_value = alu_sum and disp_neg = 0; alu_c8 = 1 SHALL set err (result above 255).
REQ-028 In CAPTURE when subtracting with alu_alb = 1: disp_value = (~alu_sum)+1 and disp_neg = 1; otherwise disp_value = alu_sum and disp_neg = 0.
REQ-029 result_valid SHALL pulse in the cycle after CAPTURE, as the FSM enters SHOW; latency from the EQUALS strobe to result_valid is 3 cycles.
REQ-030 In SHOW, a digit SHALL start a new ENTER_A with acc = d, clear disp_neg and clear err.
REQ-031 CLEAR in any state SHALL behave exactly as reset, except that it takes effect on the next edge.
REQ-032 key_valid SHALL be ignored in EXEC and CAPTURE; no buffering.
REQ-033 A key outside 0-13 SHALL be ignored in every state.

Reset
REQ-034 On rst, the FSM SHALL enter ENTER_A, and acc, alu_a, alu_b, alu_add_sub, disp_value, disp_neg, err and result_valid SHALL all be 0.
REQ-035 On rst, state_o SHALL show ENTER_A.
REQ-036 rst SHALL have priority over key_valid in the same cycle.

Configuration
REQ-037 With CALC_CHAIN_EN defined, PLUS or MINUS in SHOW SHALL load alu_a with the captured result, set the operation, clear acc and enter ENTER_B.
REQ-038 With CALC_CHAIN_EN defined, a negative result SHALL instead set err and stay in SHOW.
REQ-039 Without CALC_CHAIN_EN, PLUS and MINUS in SHOW SHALL be ignored.

Structure
REQ-040 Package calc_pkg SHALL hold the key-code constants, the state enum (3-bit encoding) and the constant OP_ADD=0/OP_SUB=1.
REQ-041 Sub-module dec_accum SHALL implement the digit accumulator: clear/load/digit-in, 8-bit acc, digit count and overflow flag.
REQ-042 The ALU SHALL NOT be instantiated inside calc_sequencer; the ALU connects at the top level.

Verification
REQ-043 The bench SHALL cover: keys 6,3,+,6,2,= with ALU 63+62 -> result_valid 3 cycles after =, disp_value=125, disp_neg=0, err=0.
REQ-044 The bench SHALL cover: keys 6,2,-,6,3,= -> alu_add_sub=1, disp_value=1, disp_neg=1.
REQ-045 The bench SHALL cover: keys 2,0,0,+,1,0,0,= -> alu_c8=1, err=1.
REQ-046 The bench SHALL cover: keys 2,5,6 -> third digit rejected, disp_value=25, err=1; then 9 -> rejected again.
REQ-047 The bench SHALL cover: CLEAR mid ENTER_B, and rst asserted in EXEC -> all outputs 0 next cycle, state ENTER_A.
REQ-048 The bench SHALL cover, with CALC_CHAIN_EN: 5,+,3,= then +,2,= -> second result disp_value=10; without it, second + is ignored and disp_value stays 8.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, FSM states, ALU op select.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_EQ    = 4'd12;
  localparam logic [3:0] KEY_CLR   = 4'd13;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_sequencer_dec_accum.sv
// Decimal operand accumulator: acc = acc*10 + d, rejecting digits past 255 or MAX_DIGITS.
module dec_accum #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       digit_vld_i,
  input  logic [3:0] digit_i,
  output logic [7:0] acc_o,
  output logic [7:0] acc_nxt_o,
  output logic       ovf_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [7:0]    acc_q;
  logic [CW-1:0] cnt_q;
  logic [11:0]   wide;

  // 255*10+9 fits in 12 bits, so the range test never wraps
  assign wide      = {4'd0, acc_q} * 12'd10 + {8'd0, digit_i};
  assign ovf_o     = digit_vld_i && ((wide > 12'd255) || (cnt_q >= CW'(MAX_DIGITS)));
  assign acc_o     = acc_q;
  assign acc_nxt_o = wide[7:0];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= {4'd0, digit_i};
      cnt_q <= CW'(1);
    end else if (digit_vld_i && !ovf_o) begin
      acc_q <= wide[7:0];
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for an external add/sub ALU. Define CALC_CHAIN_EN to let
// PLUS/MINUS in SHOW chain the displayed result into a new operation.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_add_sub,
  input  logic [7:0] alu_sum,
  input  logic       alu_c8,
  input  logic       alu_alb,
  input  logic       alu_agb,
  input  logic       alu_aeb,
  output logic [7:0] disp_value,
  output logic       disp_neg,
  output logic       err,
  output logic       result_valid,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic       op_q, op_d, neg_q, neg_d, err_q, err_d, rv_q, rv_d;
  logic       acc_clr, acc_load, acc_dig, acc_ovf;
  logic [7:0] acc, acc_nxt;
  logic       key_live, is_dig, is_op, is_eq, is_clr;
  logic       unused_flags;

  assign unused_flags = alu_agb ^ alu_aeb;

  assign key_live = key_valid && (key_code <= KEY_CLR);
  assign is_dig   = key_live && is_digit(key_code);
  assign is_op    = key_live && ((key_code == KEY_PLUS) || (key_code == KEY_MINUS));
  assign is_eq    = key_live && (key_code == KEY_EQ);
  assign is_clr   = key_live && (key_code == KEY_CLR);

  dec_accum #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (acc_clr),
    .load_i     (acc_load),
    .digit_vld_i(acc_dig),
    .digit_i    (key_code),
    .acc_o      (acc),
    .acc_nxt_o  (acc_nxt),
    .ovf_o      (acc_ovf)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    disp_d   = disp_q;
    neg_d    = neg_q;
    err_d    = err_q;
    rv_d     = 1'b0;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    acc_dig  = 1'b0;
    if (is_clr) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = OP_ADD;
      disp_d  = '0;
      neg_d   = 1'b0;
      err_d   = 1'b0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (is_dig) begin
            acc_dig = 1'b1;
            if (acc_ovf) err_d  = 1'b1;
            else         disp_d = acc_nxt;
          end else if (is_op) begin
            op_d = (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
            if (state_q == ENTER_A) begin
              a_d     = acc;
              acc_clr = 1'b1;
              state_d = ENTER_B;
            end
          end else if (is_eq && state_q == ENTER_B) begin
            b_d     = acc;
            state_d = EXEC;
          end
        end
        EXEC: state_d = CAPTURE;
        CAPTURE: begin
          // a borrow on subtract means B > A: show the two's-complement magnitude
          if (op_q == OP_SUB && alu_alb) begin
            disp_d = ~alu_sum + 8'd1;
            neg_d  = 1'b1;
          end else begin
            disp_d = alu_sum;
            neg_d  = 1'b0;
          end
          if (op_q == OP_ADD && alu_c8) err_d = 1'b1;
          rv_d    = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          if (is_dig) begin
            acc_load = 1'b1;
            disp_d   = {4'd0, key_code};
            neg_d    = 1'b0;
            err_d    = 1'b0;
            state_d  = ENTER_A;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            if (neg_q) begin
              err_d = 1'b1;
            end else begin
              a_d     = disp_q;
              op_d    = (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
              acc_clr = 1'b1;
              state_d = ENTER_B;
            end
          end
`endif
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_add_sub  = op_q;
  assign disp_value   = disp_q;
  assign disp_neg     = neg_q;
  assign err          = err_q;
  assign result_valid = rv_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed + random keypad stimulus against a per-key behavioural calculator model.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] alu_a, alu_b, alu_sum, disp_value;
  logic       alu_add_sub, alu_c8, alu_alb, alu_agb, alu_aeb;
  logic       disp_neg, err, result_valid;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // behavioural ALU on the DUT's operand bus
  assign alu_sum = alu_add_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_c8  = alu_add_sub ? (alu_a >= alu_b) : ((int'(alu_a) + int'(alu_b)) > 255);
  assign alu_alb = alu_a < alu_b;
  assign alu_agb = alu_a > alu_b;
  assign alu_aeb = alu_a == alu_b;

  calc_sequencer #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_add_sub(alu_add_sub),
    .alu_sum(alu_sum), .alu_c8(alu_c8), .alu_alb(alu_alb), .alu_agb(alu_agb), .alu_aeb(alu_aeb),
    .disp_value(disp_value), .disp_neg(disp_neg), .err(err),
    .result_valid(result_valid), .state_o(state_o)
  );

  // reference model state
  state_e m_ph = ENTER_A;
  int m_acc = 0, m_nd = 0, m_a = 0, m_b = 0, m_sub = 0;
  int m_disp = 0, m_neg = 0, m_err = 0, m_rv = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = ENTER_A; m_acc = 0; m_nd = 0; m_a = 0; m_b = 0; m_sub = 0;
    m_disp = 0; m_neg = 0; m_err = 0; m_rv = 0;
  endtask

  task automatic m_step(input logic r, input logic kv, input int kc);
    bit ok;
    int res;
    if (r || (kv && kc == 13)) begin
      m_reset();
      return;
    end
    ok = kv && kc <= 12;
    m_rv = 0;
    case (m_ph)
      ENTER_A, ENTER_B: begin
        if (ok && kc <= 9) begin
          if (m_nd >= MAXD || m_acc * 10 + kc > 255) m_err = 1;
          else begin m_acc = m_acc * 10 + kc; m_nd++; m_disp = m_acc; end
        end else if (ok && (kc == 10 || kc == 11)) begin
          m_sub = (kc == 11);
          if (m_ph == ENTER_A) begin m_a = m_acc; m_acc = 0; m_nd = 0; m_ph = ENTER_B; end
        end else if (ok && kc == 12 && m_ph == ENTER_B) begin
          m_b = m_acc; m_ph = EXEC;
        end
      end
      EXEC: m_ph = CAPTURE;
      CAPTURE: begin
        if (m_sub != 0) begin
          res = m_a - m_b;
          m_neg  = (res < 0);
          m_disp = (res < 0) ? -res : res;
        end else begin
          res = m_a + m_b;
          m_neg  = 0;
          m_disp = res % 256;
          if (res > 255) m_err = 1;
        end
        m_rv = 1;
        m_ph = SHOW;
      end
      SHOW: begin
        if (ok && kc <= 9) begin
          m_acc = kc; m_nd = 1; m_disp = kc; m_neg = 0; m_err = 0; m_ph = ENTER_A;
        end
`ifdef CALC_CHAIN_EN
        else if (ok && (kc == 10 || kc == 11)) begin
          if (m_neg != 0) m_err = 1;
          else begin
            m_a = m_disp; m_sub = (kc == 11); m_acc = 0; m_nd = 0; m_ph = ENTER_B;
          end
        end
`endif
      end
      default: m_reset();
    endcase
  endtask

  task automatic cmp_all();
    chk("state", 32'(state_o), 32'(m_ph));
    chk("disp_value", 32'(disp_value), 32'(m_disp));
    chk("disp_neg", 32'(disp_neg), 32'(m_neg));
    chk("err", 32'(err), 32'(m_err));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_add_sub", 32'(alu_add_sub), 32'(m_sub));
  endtask

  task automatic tick(input logic r, input logic kv, input logic [3:0] kc);
    rst = r; key_valid = kv; key_code = kc;
    @(posedge clk);
    m_step(r, kv, int'(kc));
    #1;
    rst = 1'b0; key_valid = 1'b0;
    cmp_all();
  endtask

  task automatic press(input int k);
    tick(1'b0, 1'b1, 4'(k));
    tick(1'b0, 1'b0, 4'd0);
  endtask

  // EQUALS then the fixed three-cycle walk to SHOW
  task automatic equals();
    tick(1'b0, 1'b1, KEY_EQ);
    chk("lat_exec", 32'(result_valid), 32'd0);
    tick(1'b0, 1'b0, 4'd0);
    chk("lat_cap", 32'(result_valid), 32'd0);
    tick(1'b0, 1'b0, 4'd0);
    chk("lat_show", 32'(result_valid), 32'd1);
  endtask

  initial begin
    logic r, kv;
    logic [3:0] kc;

    tick(1'b1, 1'b1, 4'd7);
    chk("rst_state", 32'(state_o), 32'(ENTER_A));
    chk("rst_disp", 32'(disp_value), 32'd0);

    press(6); press(3); press(10); press(6); press(2);
    equals();
    chk("add_disp", 32'(disp_value), 32'd125);
    chk("add_neg", 32'(disp_neg), 32'd0);
    chk("add_err", 32'(err), 32'd0);

    press(13);
    press(6); press(2); press(11); press(6); press(3);
    chk("sub_op", 32'(alu_add_sub), 32'd1);
    equals();
    chk("sub_disp", 32'(disp_value), 32'd1);
    chk("sub_neg", 32'(disp_neg), 32'd1);

    press(13);
    press(2); press(0); press(0); press(10); press(1); press(0); press(0);
    equals();
    chk("ovf_err", 32'(err), 32'd1);

    press(13);
    press(2); press(5); press(6);
    chk("rng_disp", 32'(disp_value), 32'd25);
    chk("rng_err", 32'(err), 32'd1);
    press(9);
    chk("cnt_disp", 32'(disp_value), 32'd25);
    chk("cnt_err", 32'(err), 32'd1);

    press(13);
    press(1); press(10); press(2);
    press(13);
    chk("clr_state", 32'(state_o), 32'(ENTER_A));
    chk("clr_alu_a", 32'(alu_a), 32'd0);
    press(1); press(10); press(2);
    tick(1'b0, 1'b1, KEY_EQ);
    chk("pre_rst_state", 32'(state_o), 32'(EXEC));
    tick(1'b1, 1'b0, 4'd0);
    chk("rst_exec_state", 32'(state_o), 32'(ENTER_A));
    chk("rst_exec_alu_b", 32'(alu_b), 32'd0);

    press(5); press(10); press(3);
    equals();
    chk("chain_first", 32'(disp_value), 32'd8);
    press(10);
`ifdef CALC_CHAIN_EN
    press(2);
    equals();
    chk("chain_second", 32'(disp_value), 32'd10);
`else
    chk("chain_hold", 32'(disp_value), 32'd8);
    chk("chain_state", 32'(state_o), 32'(SHOW));
`endif

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      kv = ($urandom_range(0, 2) != 0);
      kc = 4'($urandom_range(0, 15));
      if (kc == KEY_CLR && $urandom_range(0, 3) != 0) kc = 4'($urandom_range(0, 9));
      if (kc == KEY_CLR && (m_ph == EXEC || m_ph == CAPTURE)) kc = KEY_EQ;
      tick(r, kv, kc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
